// File: rtl/pwm_capture.sv
// pwm_capture: measures period and high time of an asynchronous PWM line.
// The line passes through a two-flop synchronizer. Rising edges reload two
// saturating counters. A small FSM publishes each complete window as a one-cycle
// o_valid strobe. It also flags a line that has no rising edge within the counter
// range.
module pwm_capture #(
    parameter int CNT_W = 8
) (
    input  logic             i_clk,
    input  logic             i_rst_n,
    input  logic             i_pwm,
    output logic [CNT_W-1:0] o_period,
    output logic [CNT_W-1:0] o_high,
    output logic             o_valid,
    output logic             o_stuck,
    output logic             o_level
);

    localparam logic [CNT_W-1:0] CNT_MAX  = {CNT_W{1'b1}};
    localparam logic [CNT_W-1:0] CNT_ONE  = {{(CNT_W-1){1'b0}}, 1'b1};
    localparam logic [CNT_W-1:0] CNT_ZERO = {CNT_W{1'b0}};

    // IDLE: no reference edge yet; ARMED: counting a valid window;
    // STUCK: the window overflowed and the next edge only re-arms.
    typedef enum logic [1:0] {
        ST_IDLE  = 2'b00,
        ST_ARMED = 2'b01,
        ST_STUCK = 2'b10
    } state_t;

    state_t           state_q, state_d;
    logic             sync1_q;
    logic             pwm_s_q;
    logic             pwm_d_q;
    logic [CNT_W-1:0] per_cnt_q, per_cnt_d;
    logic [CNT_W-1:0] hi_cnt_q, hi_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic [CNT_W-1:0] high_q, high_d;
    logic             valid_q, valid_d;
    logic             stuck_q, stuck_d;
    logic             rise_s;

    assign rise_s = pwm_s_q & ~pwm_d_q;

    // Saturating window counters; a rising edge reloads both to one because
    // the edge cycle itself is the first high cycle of the new window.
    always_comb begin
        per_cnt_d = per_cnt_q;
        hi_cnt_d  = hi_cnt_q;
        if (rise_s) begin
            per_cnt_d = CNT_ONE;
            hi_cnt_d  = CNT_ONE;
        end else begin
            if (per_cnt_q != CNT_MAX) begin
                per_cnt_d = per_cnt_q + CNT_ONE;
            end else begin
                per_cnt_d = per_cnt_q;
            end
            if (pwm_s_q && (hi_cnt_q != CNT_MAX)) begin
                hi_cnt_d = hi_cnt_q + CNT_ONE;
            end else begin
                hi_cnt_d = hi_cnt_q;
            end
        end
    end

    // Control FSM: arms on the first edge, publishes a result on each later
    // edge, and discards any window that hit counter saturation.
    always_comb begin
        state_d  = state_q;
        period_d = period_q;
        high_d   = high_q;
        valid_d  = 1'b0;
        stuck_d  = stuck_q;
        case (state_q)
            ST_IDLE: begin
                if (rise_s) begin
                    state_d = ST_ARMED;
                end else if (per_cnt_q == CNT_MAX) begin
                    state_d = ST_STUCK;
                    stuck_d = 1'b1;
                end else begin
                    state_d = ST_IDLE;
                end
            end
            ST_ARMED: begin
                if (rise_s) begin
                    period_d = per_cnt_q;
                    high_d   = hi_cnt_q;
                    valid_d  = 1'b1;
                end else if (per_cnt_q == CNT_MAX) begin
                    state_d = ST_STUCK;
                    stuck_d = 1'b1;
                end else begin
                    state_d = ST_ARMED;
                end
            end
            ST_STUCK: begin
                if (rise_s) begin
                    state_d = ST_ARMED;
                    stuck_d = 1'b0;
                end else begin
                    state_d = ST_STUCK;
                end
            end
            default: begin
                state_d = ST_IDLE;
                stuck_d = 1'b0;
            end
        endcase
    end

    // All state: synchronizer, edge-detect delay, counters, FSM and outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst_n) begin
            sync1_q   <= 1'b0;
            pwm_s_q   <= 1'b0;
            pwm_d_q   <= 1'b0;
            per_cnt_q <= CNT_ZERO;
            hi_cnt_q  <= CNT_ZERO;
            state_q   <= ST_IDLE;
            period_q  <= CNT_ZERO;
            high_q    <= CNT_ZERO;
            valid_q   <= 1'b0;
            stuck_q   <= 1'b0;
        end else begin
            sync1_q   <= i_pwm;
            pwm_s_q   <= sync1_q;
            pwm_d_q   <= pwm_s_q;
            per_cnt_q <= per_cnt_d;
            hi_cnt_q  <= hi_cnt_d;
            state_q   <= state_d;
            period_q  <= period_d;
            high_q    <= high_d;
            valid_q   <= valid_d;
            stuck_q   <= stuck_d;
        end
    end

    assign o_period = period_q;
    assign o_high   = high_q;
    assign o_valid  = valid_q;
    assign o_stuck  = stuck_q;
    assign o_level  = pwm_s_q;

endmodule

// File: tb/tb_pwm_capture.sv
// Testbench for pwm_capture.
// The driver records the input waveform cycle by cycle. From the rising edges of
// that waveform it predicts each window's period, high time and validity, and
// queues the predictions. A monitor pops the queued predictions and compares them
// with the DUT outputs.
module tb_pwm_capture;

    localparam int MAXV = 255;

    logic       clk = 1'b0;
    logic       i_rst_n = 1'b0;
    logic       i_pwm = 1'b0;
    logic [7:0] o_period;
    logic [7:0] o_high;
    logic       o_valid;
    logic       o_stuck;
    logic       o_level;

    pwm_capture #(.CNT_W(8)) dut (
        .i_clk   (clk),
        .i_rst_n (i_rst_n),
        .i_pwm   (i_pwm),
        .o_period(o_period),
        .o_high  (o_high),
        .o_valid (o_valid),
        .o_stuck (o_stuck),
        .o_level (o_level)
    );

    always #5 clk = ~clk;

    typedef struct {
        int n;
        int per;
        int hi;
    } meas_t;

    typedef struct {
        int n;
        bit valid;
        bit stuck;
        bit level;
        int per;
        int hi;
    } stat_t;

    meas_t meas_q[$];
    stat_t stat_q[$];

    int total = 0;
    int bad = 0;
    int edge_n = 0;
    bit done = 1'b0;

    // Input waveform history; w[n] is the value presented before clock edge n.
    bit w [0:32767];
    int prev_rise = -1;
    int rst_edge = 1;
    int hold_per = 0;
    int hold_hi = 0;

    always @(posedge clk) edge_n <= edge_n + 1;

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s at edge %0d: got %0d expected %0d", nm, edge_n, act, exp);
        end
    endtask

    // Drive one cycle and predict what the outputs show after that edge.
    // The model works on input rise times: a window runs from one input rise to
    // the next. The window is reported when an earlier rise exists since reset
    // and the window length is no more than MAXV. It appears two edges after the
    // input rise because of the synchronizer.
    task automatic step(input bit v, input bit rn);
        int n;
        int cnt;
        stat_t s;
        meas_t m;
        @(negedge clk);
        n = edge_n + 1;
        i_pwm = v;
        i_rst_n = rn;
        w[n] = v;
        s.n = n;
        s.valid = 1'b0;
        s.stuck = 1'b0;
        s.level = 1'b0;
        if (!rn) begin
            prev_rise = -1;
            rst_edge = n;
            hold_per = 0;
            hold_hi = 0;
        end else begin
            s.level = w[n-1];
            if ((n - 2 > rst_edge) && w[n-2] && !w[n-3]) begin
                if (prev_rise >= 0 && (n - 2 - prev_rise) <= MAXV) begin
                    cnt = 0;
                    for (int i = prev_rise; i < n - 2; i++) cnt += int'(w[i]);
                    m.n = n;
                    m.per = n - 2 - prev_rise;
                    m.hi = cnt;
                    meas_q.push_back(m);
                    hold_per = m.per;
                    hold_hi = cnt;
                    s.valid = 1'b1;
                end
                prev_rise = n - 2;
            end else if (prev_rise >= 0) begin
                s.stuck = (n >= prev_rise + 2 + MAXV);
            end else begin
                s.stuck = (n >= rst_edge + MAXV + 1);
            end
        end
        s.per = hold_per;
        s.hi = hold_hi;
        stat_q.push_back(s);
    endtask

    task automatic pwm(input int h, input int p, input int reps);
        for (int r = 0; r < reps; r++) begin
            for (int c = 0; c < p; c++) step((c < h) ? 1'b1 : 1'b0, 1'b1);
        end
    endtask

    task automatic do_reset(input int cycles);
        for (int c = 0; c < cycles; c++) step(1'b0, 1'b0);
    endtask

    // Monitor: per-edge status comparison plus measurement scoreboard pop on o_valid.
    initial begin
        stat_t s;
        meas_t m;
        forever begin
            @(posedge clk);
            #1;
            if (!done && edge_n >= 2) begin
                if (stat_q.size() == 0) begin
                    total++;
                    bad++;
                    $display("FAIL status_queue at edge %0d: got empty expected entry", edge_n);
                end else begin
                    s = stat_q.pop_front();
                    chk("edge_align", edge_n, s.n);
                    chk("o_valid", {31'd0, o_valid}, {31'd0, s.valid});
                    chk("o_stuck", {31'd0, o_stuck}, {31'd0, s.stuck});
                    chk("o_level", {31'd0, o_level}, {31'd0, s.level});
                    chk("o_period", {24'd0, o_period}, s.per);
                    chk("o_high", {24'd0, o_high}, s.hi);
                end
                chk("valid_stuck_excl", {31'd0, o_valid & o_stuck}, 32'd0);
                if (o_valid) begin
                    if (meas_q.size() == 0) begin
                        total++;
                        bad++;
                        $display("FAIL meas_queue at edge %0d: got o_valid expected none", edge_n);
                    end else begin
                        m = meas_q.pop_front();
                        chk("meas_latency", edge_n, m.n);
                        chk("meas_period", {24'd0, o_period}, m.per);
                        chk("meas_high", {24'd0, o_high}, m.hi);
                    end
                end
            end
        end
    end

    // Stimulus sequence.
    initial begin
        int p;
        int h;
        do_reset(4);
        repeat (3) step(1'b0, 1'b1);
        pwm(3, 10, 6);
        pwm(7, 10, 5);
        repeat (300) step(1'b0, 1'b1);
        pwm(4, 12, 4);
        repeat (300) step(1'b1, 1'b1);
        pwm(4, 12, 4);
        pwm(5, 20, 3);
        repeat (5) step(1'b1, 1'b1);
        repeat (4) step(1'b0, 1'b1);
        do_reset(2);
        pwm(5, 20, 4);
        pwm(1, 2, 8);
        pwm(9, 10, 5);
        pwm(10, 255, 3);
        pwm(10, 256, 3);
        pwm(2, 6, 3);
        for (int k = 0; k < 40; k++) begin
            p = int'($urandom_range(40, 2));
            h = int'($urandom_range(p - 1, 1));
            pwm(h, p, 1 + int'($urandom_range(2, 0)));
        end
        for (int k = 0; k < 200; k++) step(1'(($urandom_range(1, 0))), 1'b1);
        repeat (20) step(1'b0, 1'b1);
        @(posedge clk);
        #2;
        done = 1'b1;
        chk("meas_queue_drained", meas_q.size(), 32'd0);
        chk("status_queue_drained", stat_q.size(), 32'd0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
